// File: rtl/sr_arb_pkg.sv
// Shared types and grant encodings for the two-requester shared-register arbiter.
package sr_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  function automatic logic [1:0] gnt_of(arb_state_t s);
    case (s)
      OWN0:    gnt_of = GNT_0;
      OWN1:    gnt_of = GNT_1;
      default: gnt_of = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_ffd_sr.sv
// D register with synchronous active-high reset and load enable; reset wins over load.
module reg_ffd_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared register,
// with forced rotation after HOLD_MAX owner cycles while the other side waits.
module shared_reg_arbiter
  import sr_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       we,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] HOLD_TOP  = CW'(HOLD_MAX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req == 2'b01)      state_d = OWN0;
        else if (req == 2'b10) state_d = OWN1;
        else if (req == 2'b11) state_d = last_q ? OWN0 : OWN1;
      end
      OWN0: begin
        if (req[0] && req[1]) begin
          if (hold_q >= HOLD_LAST) state_d = OWN1;
          else                     hold_d  = hold_q + CW'(1);
        end else if (req[0]) begin
          if (hold_q != HOLD_TOP)  hold_d  = hold_q + CW'(1);
        end else begin
          state_d = req[1] ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (req[1] && req[0]) begin
          if (hold_q >= HOLD_LAST) state_d = OWN0;
          else                     hold_d  = hold_q + CW'(1);
        end else if (req[1]) begin
          if (hold_q != HOLD_TOP)  hold_d  = hold_q + CW'(1);
        end else begin
          state_d = req[0] ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Entering an ownership state restarts the tenure and records the new owner.
    if (state_d != state_q && state_d == OWN0) begin
      last_d = 1'b0;
      hold_d = '0;
    end else if (state_d != state_q && state_d == OWN1) begin
      last_d = 1'b1;
      hold_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      gnt_q   <= GNT_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt_q   <= gnt_of(state_d);
    end
  end

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  assign wr_en   = (gnt_q[0] & we[0]) | (gnt_q[1] & we[1]);
  assign wr_data = gnt_q[1] ? wdata1 : wdata0;

  reg_ffd_sr #(.WIDTH(WIDTH)) u_reg (
    .clock (clock),
    .reset (reset),
    .en    (wr_en),
    .d     (wr_data),
    .q     (rdata)
  );

  assign gnt  = gnt_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed scenarios plus random traffic
// checked against an integer-level ownership model.
module tb_shared_reg_arbiter;

  localparam int W = 8;
  localparam int H = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req, we;
  logic [W-1:0] wdata0, wdata1;
  logic [1:0]   gnt;
  logic [W-1:0] rdata;
  logic         busy;

  shared_reg_arbiter #(.WIDTH(W), .HOLD_MAX(H)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .we    (we),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .gnt   (gnt),
    .rdata (rdata),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   g;
    logic [W-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: owner index (-1 = nobody), tenure cycles, last winner, stored value.
  int           m_owner = -1;
  int           m_ten   = 0;
  int           m_last  = 1;
  logic [W-1:0] m_reg   = '0;

  task automatic model_step();
    int o, x;
    if (reset) begin
      m_owner = -1; m_ten = 0; m_last = 1; m_reg = '0;
      return;
    end
    if (m_owner >= 0 && we[m_owner])
      m_reg = (m_owner == 0) ? wdata0 : wdata1;
    if (m_owner < 0) begin
      if (req == 2'b11)    begin m_owner = 1 - m_last; m_ten = 0; m_last = m_owner; end
      else if (req[0])     begin m_owner = 0; m_ten = 0; m_last = 0; end
      else if (req[1])     begin m_owner = 1; m_ten = 0; m_last = 1; end
    end else begin
      o = m_owner; x = 1 - o;
      if (req[o] && req[x]) begin
        if (m_ten >= H - 1) begin m_owner = x; m_ten = 0; m_last = x; end
        else m_ten++;
      end else if (req[o]) begin
        if (m_ten < H) m_ten++;
      end else if (req[x]) begin
        m_owner = x; m_ten = 0; m_last = x;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [1:0] model_gnt();
    if (m_owner == 0) return 2'b01;
    if (m_owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: outputs are always valid, so every cycle retires one scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_gnt", {30'd0, gnt}, {30'd0, e.g});
      chk("sb_rdata", {24'd0, rdata}, {24'd0, e.r});
      chk("sb_busy", {31'd0, busy}, {31'd0, |e.g});
    end
  end

  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [W-1:0] d0, input logic [W-1:0] d1, input logic rs);
    exp_t e;
    req = r; we = w; wdata0 = d0; wdata1 = d1; reset = rs;
    @(posedge clock);
    model_step();
    e.g = model_gnt();
    e.r = m_reg;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    req = 2'b00; we = 2'b00; wdata0 = '0; wdata1 = '0; reset = 1'b1;
    @(negedge clock);

    // 1: reset with requests and writes pending
    for (int i = 0; i < 2; i++) begin
      step(2'b11, 2'b11, 8'h11, 8'h22, 1'b1);
      chk("t1_gnt", {30'd0, gnt}, 32'h0);
      chk("t1_rdata", {24'd0, rdata}, 32'h0);
      chk("t1_busy", {31'd0, busy}, 32'h0);
    end

    // 2: single requester grant latency and write visibility
    step(2'b01, 2'b01, 8'hA5, 8'h00, 1'b0);
    chk("t2_gnt", {30'd0, gnt}, 32'h1);
    chk("t2_nowrite_yet", {24'd0, rdata}, 32'h0);
    step(2'b01, 2'b01, 8'hA5, 8'h00, 1'b0);
    chk("t2_rdata", {24'd0, rdata}, 32'hA5);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

    // 3: tie after reset goes to requester 0, forced rotation after HOLD_MAX cycles
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < H; i++) begin
      step(2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
      chk("t3_own0", {30'd0, gnt}, 32'h1);
    end
    step(2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("t3_rotate", {30'd0, gnt}, 32'h2);

    // 4: owner drops while the other waits -> direct handover
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b01, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("t4_own0", {30'd0, gnt}, 32'h1);
    step(2'b10, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("t4_handover", {30'd0, gnt}, 32'h2);

    // 5: write from the non-owner is ignored
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b01, 2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b01, 2'b01, 8'h5A, 8'h00, 1'b0);
    step(2'b01, 2'b10, 8'h00, 8'h3C, 1'b0);
    chk("t5_ignored", {24'd0, rdata}, 32'h5A);

    // 6: mid-operation reset discards the pending write, then tie goes to 0
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b10, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("t6_own1", {30'd0, gnt}, 32'h2);
    step(2'b10, 2'b10, 8'h00, 8'hFF, 1'b1);
    chk("t6_gnt", {30'd0, gnt}, 32'h0);
    chk("t6_rdata", {24'd0, rdata}, 32'h0);
    step(2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("t6_tie", {30'd0, gnt}, 32'h1);

    // Random traffic with occasional resets
    for (int i = 0; i < 1000; i++) begin
      step(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 49) == 0));
      if (gnt == 2'b11) chk("rand_onehot", {30'd0, gnt}, 32'h0);
    end

    @(negedge clock);
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
